// File: rtl/r16_fft_pkg.sv
// Shared types, constants and the stage address map for the radix-16 FFT scheduler.
package r16_fft_pkg;

  localparam int A_WIDTH       = 9;
  localparam int GRP_W         = A_WIDTH + 1;
  localparam int GRP_PER_STAGE = 1 << GRP_W;
  localparam int NUM_STAGES    = 4;
  localparam int PIPE_LAT      = 48;
  localparam int ROT_BITS      = 4;
  localparam int STAGE_W       = $clog2(NUM_STAGES);
  localparam int DRAIN_W       = $clog2(PIPE_LAT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sched_state_t;

  typedef struct packed {
    logic               bn;
    logic [A_WIDTH-1:0] ma;
  } addr_t;

  // Rotate the group counter left by one radix-16 digit per stage, then split into bank/address.
  function automatic addr_t addr_map(input logic [GRP_W-1:0]   grp,
                                     input logic [STAGE_W-1:0] stage);
    logic [2*GRP_W-1:0] dbl;
    logic [GRP_W-1:0]   idx;
    addr_t              r;
    int                 sh;
    sh   = (ROT_BITS * int'(stage)) % GRP_W;
    dbl  = {grp, grp} << sh;
    idx  = dbl[2*GRP_W-1 -: GRP_W];
    r.bn = ^idx;
    r.ma = idx[GRP_W-1:1];
    return r;
  endfunction

endpackage

// File: rtl/r16_addr_map.sv
// Combinational group-counter to bank/address mapper for one FFT stage.
module r16_addr_map
  import r16_fft_pkg::*;
(
  input  logic [GRP_W-1:0]   grp,
  input  logic [STAGE_W-1:0] stage,
  output logic               bn,
  output logic [A_WIDTH-1:0] ma
);

  addr_t m;

  assign m  = addr_map(grp, stage);
  assign bn = m.bn;
  assign ma = m.ma;

endmodule

// File: rtl/r16_stage_sched.sv
// Stage scheduler for the memory-based radix-16 16384-point FFT: read BN/MA per group, drain gap per stage.
// Optional build macro R16_SCHED_STALL_EN adds stall_in, which freezes RUN/DRAIN.
module r16_stage_sched
  import r16_fft_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_in,
`ifdef R16_SCHED_STALL_EN
  input  logic               stall_in,
`endif
  output logic               BN_out,
  output logic [A_WIDTH-1:0] MA_out,
  output logic               rd_en_out,
  output logic [1:0]         stage_out,
  output logic               busy_out,
  output logic               done_out
);

  sched_state_t       state;
  logic [GRP_W-1:0]   grp_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               stall;
  logic               map_bn;
  logic [A_WIDTH-1:0] map_ma;

`ifdef R16_SCHED_STALL_EN
  assign stall = stall_in;
`else
  assign stall = 1'b0;
`endif

  r16_addr_map u_map (
    .grp   (grp_cnt),
    .stage (stage_out),
    .bn    (map_bn),
    .ma    (map_ma)
  );

  // grp_cnt always holds the next group to issue; group 0 goes out on the start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grp_cnt   <= '0;
      drain_cnt <= '0;
      BN_out    <= 1'b0;
      MA_out    <= '0;
      rd_en_out <= 1'b0;
      stage_out <= '0;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
    end else begin
      rd_en_out <= 1'b0;
      done_out  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            state     <= RUN;
            busy_out  <= 1'b1;
            rd_en_out <= 1'b1;
            BN_out    <= map_bn;
            MA_out    <= map_ma;
            grp_cnt   <= grp_cnt + GRP_W'(1);
          end
        end
        RUN: begin
          if (!stall) begin
            rd_en_out <= 1'b1;
            BN_out    <= map_bn;
            MA_out    <= map_ma;
            grp_cnt   <= grp_cnt + GRP_W'(1);
            if (grp_cnt == GRP_W'(GRP_PER_STAGE - 1)) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        DRAIN: begin
          if (!stall) begin
            if (drain_cnt == DRAIN_W'(PIPE_LAT - 1)) begin
              drain_cnt <= '0;
              if (stage_out == STAGE_W'(NUM_STAGES - 1)) begin
                state <= DONE;
              end else begin
                stage_out <= stage_out + STAGE_W'(1);
                state     <= RUN;
              end
            end else begin
              drain_cnt <= drain_cnt + DRAIN_W'(1);
            end
          end
        end
        DONE: begin
          done_out  <= 1'b1;
          busy_out  <= 1'b0;
          stage_out <= '0;
          grp_cnt   <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_r16_stage_sched.sv
// Self-checking bench for r16_stage_sched: read-order scoreboard, drain gaps, length, restart after reset.
module tb_r16_stage_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_in;
`ifdef R16_SCHED_STALL_EN
  logic       stall_in;
`endif
  logic       BN_out;
  logic [8:0] MA_out;
  logic       rd_en_out;
  logic [1:0] stage_out;
  logic       busy_out;
  logic       done_out;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct { int s; int g; } rd_t;
  typedef struct { int s; int g; logic [9:0] exp; } vec_t;

  rd_t        sb[$];
  logic [9:0] cap [4][1024];
  vec_t       vt [9];

  always #5 clk = ~clk;

  r16_stage_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_in  (start_in),
`ifdef R16_SCHED_STALL_EN
    .stall_in  (stall_in),
`endif
    .BN_out    (BN_out),
    .MA_out    (MA_out),
    .rd_en_out (rd_en_out),
    .stage_out (stage_out),
    .busy_out  (busy_out),
    .done_out  (done_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: condition not met", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: bit-by-bit rotation, returns {bn, ma}.
  function automatic logic [9:0] exp_map(input int s, input int g);
    logic [9:0] gv;
    logic [9:0] idx;
    int         sh;
    gv  = 10'(g);
    sh  = (4 * s) % 10;
    idx = '0;
    for (int i = 0; i < 10; i++) idx[(i + sh) % 10] = gv[i];
    return {^idx, idx[9:1]};
  endfunction

  task automatic run_xform(input bit noise, input int stall_len, input int abort_at,
                           input int exp_len, input bit capture);
    int         first;
    int         reads;
    int         low_run;
    int         stall_cnt;
    int         cyc;
    bit         done_seen;
    rd_t        e;
    logic [9:0] last;
    logic [9:0] x;
    sb.delete();
    for (int s = 0; s < 4; s++)
      for (int g = 0; g < 1024; g++) sb.push_back('{s, g});
    first = -1; reads = 0; low_run = 0; stall_cnt = 0; done_seen = 1'b0; last = '0;
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    for (cyc = 0; cyc < 6000 && !done_seen; cyc++) begin
      if (rd_en_out) begin
        if (reads == 0) begin
          check("first_read_latency", 32'(cyc), 32'd0);
          check("busy_on_first_read", 32'(busy_out), 32'd1);
          first = cyc;
        end
        if (reads > 0 && low_run > 0)
          check("gap_len", 32'(low_run), (reads % 1024 == 0) ? 32'd48 : 32'(stall_len));
        low_run = 0;
        if (sb.size() == 0) begin
          fail_now("read_after_last_group");
        end else begin
          e = sb.pop_front();
          x = exp_map(e.s, e.g);
          check("read_map", 32'({stage_out, BN_out, MA_out}), 32'({2'(e.s), x}));
          if (capture) cap[e.s][e.g] = {BN_out, MA_out};
          last = {BN_out, MA_out};
          if (abort_at == reads) begin
            rst_n = 1'b0;
            #2;
            check("async_reset_outputs",
                  32'({BN_out, MA_out, rd_en_out, stage_out, busy_out, done_out}), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            step();
            return;
          end
        end
        reads++;
      end else if (reads > 0 && busy_out) begin
        low_run++;
        check("hold_when_no_read", 32'({BN_out, MA_out}), 32'(last));
      end
      if (done_out) begin
        done_seen = 1'b1;
        check("transform_len", 32'(cyc - first), 32'(exp_len));
        check("busy_fall_with_done", 32'(busy_out), 32'd0);
        check("reads_total", 32'(reads), 32'd4096);
      end
      start_in = noise && (reads == 10 || reads == 500) && !rd_en_out ? 1'b0 :
                 (noise && (reads == 10 || reads == 500)) ? 1'b1 : 1'b0;
`ifdef R16_SCHED_STALL_EN
      if (stall_len > 0 && reads == 101 && stall_cnt < stall_len) begin
        stall_in = 1'b1;
        stall_cnt++;
      end else begin
        stall_in = 1'b0;
      end
`endif
      step();
    end
    start_in = 1'b0;
    if (!done_seen) begin
      fail_now("done_timeout");
    end else begin
      check("done_single_pulse", 32'(done_out), 32'd0);
      check("idle_after_done", 32'({busy_out, rd_en_out, stage_out}), 32'd0);
    end
  endtask

  initial begin
    vt[0] = '{0, 0,    {1'b0, 9'd0}};
    vt[1] = '{0, 3,    {1'b0, 9'd1}};
    vt[2] = '{0, 1023, {1'b0, 9'd511}};
    vt[3] = '{1, 1,    {1'b1, 9'd8}};
    vt[4] = '{2, 1,    {1'b1, 9'd128}};
    vt[5] = '{3, 1,    {1'b1, 9'd2}};
    vt[6] = '{3, 512,  {1'b1, 9'd1}};
    vt[7] = '{2, 3,    {1'b0, 9'd384}};
    vt[8] = '{1, 64,   {1'b1, 9'd0}};

    rst_n    = 1'b0;
    start_in = 1'b0;
`ifdef R16_SCHED_STALL_EN
    stall_in = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          32'({BN_out, MA_out, rd_en_out, stage_out, busy_out, done_out}), 32'd0);
    rst_n = 1'b1;
    repeat (3) step();
    check("idle_hold", 32'({rd_en_out, busy_out, done_out}), 32'd0);

    run_xform(1'b0, 0, -1, 4288, 1'b1);
    for (int i = 0; i < 9; i++)
      check($sformatf("table_s%0d_g%0d", vt[i].s, vt[i].g),
            32'(cap[vt[i].s][vt[i].g]), 32'(vt[i].exp));

    repeat (2) step();
    run_xform(1'b1, 0, -1, 4288, 1'b0);

    repeat (2) step();
    run_xform(1'b0, 0, 2 * 1024 + 300, 4288, 1'b0);
    check("post_reset_idle", 32'({rd_en_out, busy_out, stage_out, done_out}), 32'd0);
    repeat (2) step();
    run_xform(1'b0, 0, -1, 4288, 1'b0);

`ifdef R16_SCHED_STALL_EN
    repeat (2) step();
    run_xform(1'b0, 5, -1, 4293, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
